// File: rtl/serial_adder_if.sv
// -----------------------------------------------------------------------------
// serial_adder_if
//   Bundles the operand and result handshakes of the bit-serial adder.
//
//   Signals (named from the adder's point of view):
//     in_valid  : operand request from the producer
//     in_ready  : adder can take operands (high only while idle)
//     a, b      : WIDTH-bit operands (unsigned or two's complement)
//     cin       : carry in
//     out_valid : sum/cout/ovf valid, held until accepted
//     out_ready : consumer takes the result
//     sum       : a+b+cin modulo 2^WIDTH
//     cout      : carry out of the MSB
//     ovf       : signed overflow (carry into MSB xor carry out)
//
//   Modports:
//     master : the producer/consumer side (drives operands, accepts results)
//     slave  : the adder side
// -----------------------------------------------------------------------------
interface serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid,
      output a,
      output b,
      output cin,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  sum,
      input  cout,
      input  ovf
   );

   modport slave (
      input  in_valid,
      input  a,
      input  b,
      input  cin,
      input  out_ready,
      output in_ready,
      output out_valid,
      output sum,
      output cout,
      output ovf
   );
endinterface

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial WIDTH-bit adder, LSB first, one bit per clock. Each bit passes
//   through a half-add stage (p = a^b, g = a&b) and a second half-add against
//   the carry register, which is then updated to g | (p & carry).
//
//   Ports:
//     clk   : clock, all state changes on the rising edge
//     rst_n : synchronous active-low reset
//     bus   : serial_adder_if slave modport (operand and result handshakes)
//
//   Timing: operands accepted at edge E are processed on edges E+1..E+WIDTH;
//   out_valid is high in the cycle after E+WIDTH and stays high until an edge
//   with out_ready=1. A new operation can be accepted on the following edge,
//   giving one operation per WIDTH+2 cycles under continuous flow.
// -----------------------------------------------------------------------------
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   serial_adder_if.slave bus
);

   // Counter wide enough to hold WIDTH-1; at least one bit for WIDTH=1.
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Per-bit datapath on the current LSBs of the operand shift registers.
   logic p_bit;
   logic g_bit;
   logic s_bit;
   logic carry_nxt;

   assign p_bit     = a_sr_q[0] ^ b_sr_q[0];
   assign g_bit     = a_sr_q[0] & b_sr_q[0];
   assign s_bit     = p_bit ^ carry_q;
   assign carry_nxt = g_bit | (p_bit & carry_q);

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and datapath update
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_sr_d  = bus.a;
               b_sr_d  = bus.b;
               carry_d = bus.cin;
               cnt_d   = '0;
               state_d = RUN;
            end
         end

         RUN: begin
            // Sum shifts right with the new bit entering at the MSB; after
            // WIDTH edges every stale bit from the previous result is gone.
            sum_d              = sum_q >> 1;
            sum_d[WIDTH-1]     = s_bit;
            a_sr_d             = a_sr_q >> 1;
            b_sr_d             = b_sr_q >> 1;
            carry_d            = carry_nxt;
            cnt_d              = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
               // While the MSB is being processed, carry_q holds the carry
               // into the MSB (cin when WIDTH=1), so no separate capture
               // register is needed for the overflow term.
               cout_d  = carry_nxt;
               ovf_d   = carry_q ^ carry_nxt;
               state_d = DONE;
            end
         end

         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Outputs: all driven from registers, no input-to-output paths
   // -------------------------------------------------------------------------
   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//   Directed and randomized checks of serial_adder at WIDTH=8 and WIDTH=1.
//   Expected results come from an integer model of a+b+cin (modulo, carry and
//   signed-range overflow).
// -----------------------------------------------------------------------------
module tb_serial_adder;

   logic clk;
   logic rst_n;

   int vectors;
   int miscompares;

   serial_adder_if #(.WIDTH(8)) bus8 ();
   serial_adder_if #(.WIDTH(1)) bus1 ();

   serial_adder #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus8)
   );

   serial_adder #(.WIDTH(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Returns {ovf, cout, sum[31:0]} for a w-bit add.
   function automatic logic [33:0] model(input int w, input longint a,
                                         input longint b, input longint c);
      longint modv, half, tot, sa, sb, st;
      logic   ov, co;
      modv = longint'(1) << w;
      half = modv / 2;
      tot  = a + b + c;
      sa   = (a >= half) ? a - modv : a;
      sb   = (b >= half) ? b - modv : b;
      st   = sa + sb + c;
      ov   = (st < -half) || (st > half - 1);
      co   = (tot >= modv);
      return {ov, co, 32'(tot % modv)};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present operands for exactly one edge (edge E); returns after E.
   task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic c);
      check("in_ready_before_accept", 32'(bus8.in_ready), 32'd1);
      bus8.a        = a;
      bus8.b        = b;
      bus8.cin      = c;
      bus8.in_valid = 1'b1;
      tick();
      bus8.in_valid = 1'b0;
   endtask

   // Waits for out_valid, checking in_ready stays low while busy; the number
   // of edges after E when out_valid is seen must equal WIDTH.
   task automatic wait8(input int start);
      int cycles;
      cycles = start;
      while (!bus8.out_valid && cycles < 40) begin
         check("in_ready_busy", 32'(bus8.in_ready), 32'd0);
         tick();
         cycles++;
      end
      check("latency", 32'(cycles), 32'd8);
   endtask

   // Checks the result, optionally holding it under backpressure, then hands
   // it off with a one-edge out_ready pulse.
   task automatic finish8(input logic [7:0] a, input logic [7:0] b,
                          input logic c, input int hold);
      logic [33:0] exp;
      exp = model(8, longint'(a), longint'(b), longint'(c));
      for (int i = 0; i <= hold; i++) begin
         check("out_valid_held", 32'(bus8.out_valid), 32'd1);
         check("sum",  32'(bus8.sum),  32'(exp[7:0]));
         check("cout", 32'(bus8.cout), 32'(exp[32]));
         check("ovf",  32'(bus8.ovf),  32'(exp[33]));
         if (i < hold) tick();
      end
      bus8.out_ready = 1'b1;
      tick();
      bus8.out_ready = 1'b0;
      check("out_valid_after_handoff", 32'(bus8.out_valid), 32'd0);
      check("in_ready_after_handoff",  32'(bus8.in_ready),  32'd1);
   endtask

   task automatic op8(input logic [7:0] a, input logic [7:0] b,
                      input logic c, input int hold);
      start8(a, b, c);
      wait8(0);
      finish8(a, b, c, hold);
   endtask

   initial begin
      logic [7:0]  ra, rb;
      logic        rc;
      logic [7:0]  pa [3];
      logic [7:0]  pb [3];
      logic        pc [3];
      int          acc_cyc [3];
      int          nacc, nres, cyc;
      logic [33:0] exp;

      vectors     = 0;
      miscompares = 0;

      rst_n          = 1'b0;
      bus8.in_valid  = 1'b0;
      bus8.a         = '0;
      bus8.b         = '0;
      bus8.cin       = 1'b0;
      bus8.out_ready = 1'b0;
      bus1.in_valid  = 1'b0;
      bus1.a         = '0;
      bus1.b         = '0;
      bus1.cin       = 1'b0;
      bus1.out_ready = 1'b0;

      tick();
      tick();
      rst_n = 1'b1;

      // Reset state
      check("rst_in_ready",  32'(bus8.in_ready),  32'd1);
      check("rst_out_valid", 32'(bus8.out_valid), 32'd0);
      check("rst_sum",       32'(bus8.sum),       32'd0);
      check("rst_cout",      32'(bus8.cout),      32'd0);
      check("rst_ovf",       32'(bus8.ovf),       32'd0);
      check("rst1_in_ready", 32'(bus1.in_ready),  32'd1);
      check("rst1_out_valid",32'(bus1.out_valid), 32'd0);

      // Directed arithmetic corners
      op8(8'h00, 8'h00, 1'b0, 0);
      op8(8'hFF, 8'h01, 1'b0, 0);
      op8(8'h7F, 8'h01, 1'b0, 0);
      op8(8'h80, 8'h80, 1'b1, 0);

      // Backpressure: result held for 5 cycles
      op8(8'h3C, 8'hC5, 1'b1, 5);

      // in_valid toggling with other operands while busy is ignored
      start8(8'h12, 8'h34, 1'b0);
      for (int i = 0; i < 4; i++) begin
         bus8.a        = 8'hAA;
         bus8.b        = 8'h55;
         bus8.in_valid = ~i[0];
         tick();
      end
      bus8.in_valid = 1'b0;
      wait8(4);
      finish8(8'h12, 8'h34, 1'b0, 0);

      // Reset on the 4th RUN edge discards the operation
      start8(8'h55, 8'h66, 1'b1);
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("midrst_out_valid", 32'(bus8.out_valid), 32'd0);
      check("midrst_sum",       32'(bus8.sum),       32'd0);
      check("midrst_in_ready",  32'(bus8.in_ready),  32'd1);
      op8(8'h10, 8'h20, 1'b0, 0);

      // Randomized operations with random backpressure
      for (int i = 0; i < 8; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rc = 1'($urandom);
         op8(ra, rb, rc, int'($urandom_range(0, 3)));
      end

      // Back-to-back with in_valid and out_ready held high
      for (int i = 0; i < 3; i++) begin
         pa[i] = 8'($urandom);
         pb[i] = 8'($urandom);
         pc[i] = 1'($urandom);
      end
      nacc = 0;
      nres = 0;
      cyc  = 0;
      bus8.out_ready = 1'b1;
      bus8.in_valid  = 1'b1;
      while (nres < 3 && cyc < 200) begin
         if (nacc == 3) bus8.in_valid = 1'b0;
         if (bus8.in_ready && nacc < 3) begin
            bus8.a       = pa[nacc];
            bus8.b       = pb[nacc];
            bus8.cin     = pc[nacc];
            acc_cyc[nacc] = cyc;
            nacc++;
         end
         if (bus8.out_valid) begin
            exp = model(8, longint'(pa[nres]), longint'(pb[nres]), longint'(pc[nres]));
            check("b2b_sum",  32'(bus8.sum),  32'(exp[7:0]));
            check("b2b_cout", 32'(bus8.cout), 32'(exp[32]));
            check("b2b_ovf",  32'(bus8.ovf),  32'(exp[33]));
            nres++;
         end
         tick();
         cyc++;
      end
      bus8.in_valid  = 1'b0;
      bus8.out_ready = 1'b0;
      check("b2b_results", 32'(nres), 32'd3);
      if (nres == 3) begin
         check("b2b_spacing0", 32'(acc_cyc[1] - acc_cyc[0]), 32'd10);
         check("b2b_spacing1", 32'(acc_cyc[2] - acc_cyc[1]), 32'd10);
      end

      // WIDTH=1 instance: all operand combinations, 1+1+1 included
      for (int i = 0; i < 8; i++) begin
         int cycles;
         check("w1_in_ready", 32'(bus1.in_ready), 32'd1);
         bus1.a        = i[0];
         bus1.b        = i[1];
         bus1.cin      = i[2];
         bus1.in_valid = 1'b1;
         tick();
         bus1.in_valid = 1'b0;
         cycles = 0;
         while (!bus1.out_valid && cycles < 10) begin
            tick();
            cycles++;
         end
         exp = model(1, longint'(i[0]), longint'(i[1]), longint'(i[2]));
         check("w1_latency", 32'(cycles),        32'd1);
         check("w1_sum",     32'(bus1.sum),      32'(exp[0]));
         check("w1_cout",    32'(bus1.cout),     32'(exp[32]));
         check("w1_ovf",     32'(bus1.ovf),      32'(exp[33]));
         bus1.out_ready = 1'b1;
         tick();
         bus1.out_ready = 1'b0;
         check("w1_out_valid_after", 32'(bus1.out_valid), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder; LSB-first, one bit per clock.
- Each bit goes through two cascaded half-add stages: (a^b, a&b), then the carry register.
- Sits downstream of the combinational half-add datapath; gives a low-area adder for multi-bit operands.
- Valid/ready handshake on both operand input and result output.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1..32.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on clk rising edge.
- in_valid  input  1  operand request.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry in.
- out_valid  output  1  sum/cout/ovf valid; held until accepted.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  a+b+cin modulo 2^WIDTH.
- cout  output  1  carry out of MSB.
- ovf  output  1  signed overflow = carry into MSB XOR cout.

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE, sum=0, cout=0, ovf=0, out_valid=0, carry=0, bit counter=0.
  - Reset wins over every other input on the same edge, including mid-RUN and in DONE; any in-flight operation is discarded.
- in_ready = (state==IDLE), decoded from the registered state. It is 1 in the first cycle after reset.
- States:
  - IDLE:
    - On an edge with in_valid=1: latch a and b into shift registers A_sr and B_sr, carry=cin, cnt=0, go RUN.
    - Otherwise stay. Inputs are not sampled outside IDLE.
  - RUN, on each edge:
    - Compute p=A_sr[0]^B_sr[0], g=A_sr[0]&B_sr[0].
    - Sum bit s=p^carry; next carry=g|(p&carry).
    - Shift s into sum at bit WIDTH-1 (sum shifts right).
    - Shift A_sr and B_sr right by 1; increment cnt.
    - On the edge processing bit WIDTH-2, capture carry_msb_in = carry (the carry into the MSB). For WIDTH=1 this is cin.
    - On the edge where cnt==WIDTH-1 (last bit):
      - cout = next carry.
      - ovf = carry_msb_in ^ next carry.
      - out_valid=1; go DONE.
  - DONE:
    - out_valid=1; sum/cout/ovf stable.
    - On an edge with out_ready=1: out_valid=0, go IDLE.
    - in_valid is ignored here; a new accept is possible one cycle after the result handoff.
- Latency: operands accepted at edge E; out_valid is high in the cycle after edge E+WIDTH. Throughput is one operation per WIDTH+2 cycles when out_ready is held high.
- out_ready while not out_valid: ignored.
- in_valid held high continuously: exactly one accept per IDLE visit.
- sum is undefined-but-deterministic (partially shifted) during RUN. Consumers use it only while out_valid=1.
- Arithmetic is exactly modulo 2^WIDTH; no saturation.
- No combinational path from any input to any output except through state (in_ready depends on state only).

Test Plan:
- WIDTH=8: a=0x00, b=0x00, cin=0, accept at edge E -> out_valid after edge E+8; sum=0x00, cout=0, ovf=0; in_ready=0 from E+1 until the return to IDLE.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1. Then a=0x80, b=0x80, cin=1 -> sum=0x01, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises -> out_valid, sum, cout, ovf unchanged for all 5 cycles. Raise out_ready for one edge -> out_valid=0 and in_ready=1 next cycle.
- Mid-operation disturbance:
  - Toggle in_valid with a/b=0xAA/0x55 during RUN -> ignored; original result 0x12+0x34=0x46 delivered.
  - Assert rst_n=0 at the 4th RUN edge -> next cycle out_valid=0, sum=0, in_ready=1. Then 0x10+0x20 -> 0x30.
- Back-to-back: in_valid and out_ready held high, 3 random operand pairs -> each result correct; accepts spaced exactly WIDTH+2 cycles apart.
- WIDTH=1 instance: 1+1, cin=1 -> sum=1, cout=1, ovf=0, out_valid one cycle after accept.
